// File: rtl/md_unit_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// Radix-2^MUL_BITS shift-add multiply, restoring divide, sign fixup.
module md_unit_iter #(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] SRC_A,
   input  logic [WIDTH-1:0] SRC_B,
   input  logic             MF_REQ,
   input  logic             FLUSH,
   output logic             BUSY,
   output logic             STALL,
   output logic             DONE,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int W2 = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam logic [CW-1:0] N_MUL = CW'(WIDTH / MUL_BITS);
   localparam logic [CW-1:0] N_DIV = CW'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             divz_q, divz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;

   logic                      sgn;
   logic [WIDTH-1:0]          a_mag, b_mag;
   logic [WIDTH+MUL_BITS-1:0] mul_sum;
   logic [W2+MUL_BITS-1:0]    mul_sh;
   logic [WIDTH:0]            div_sh;
   logic [WIDTH+1:0]          div_diff;
   logic                      div_ok;
   logic [W2-1:0]             prod;
   logic [WIDTH-1:0]          quo, rem;

   always_comb begin
      sgn   = ~OP[0];
      a_mag = (sgn & SRC_A[WIDTH-1]) ? -SRC_A : SRC_A;
      b_mag = (sgn & SRC_B[WIDTH-1]) ? -SRC_B : SRC_B;

      // Upper half plus partial product, then shift the whole accumulator right
      mul_sum = {{MUL_BITS{1'b0}}, acc_q[W2-1:WIDTH]}
              + {{MUL_BITS{1'b0}}, opb_q}
              * {{WIDTH{1'b0}}, opa_q[MUL_BITS-1:0]};
      mul_sh  = {mul_sum, acc_q[WIDTH-1:0]} >> MUL_BITS;

      div_sh   = {rem_q, opa_q[WIDTH-1]};
      div_diff = {1'b0, div_sh} - {2'b00, opb_q};
      div_ok   = ~div_diff[WIDTH+1];

      prod = neg_q ? -acc_q : acc_q;
      // Divide by zero: quotient stays all ones, and the remainder
      // (|A| re-signed with A's sign) reproduces the original dividend.
      quo  = (neg_q & ~divz_q) ? -opa_q : opa_q;
      rem  = rneg_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      divz_d  = divz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               case (OP)
                  3'b000, 3'b001: begin
                     opa_d   = a_mag;
                     opb_d   = b_mag;
                     neg_d   = sgn & (SRC_A[WIDTH-1] ^ SRC_B[WIDTH-1]);
                     acc_d   = '0;
                     div_d   = 1'b0;
                     cnt_d   = N_MUL;
                     state_d = S_MUL;
                  end
                  3'b010, 3'b011: begin
                     opa_d   = a_mag;
                     opb_d   = b_mag;
                     neg_d   = sgn & (SRC_A[WIDTH-1] ^ SRC_B[WIDTH-1]);
                     rneg_d  = sgn & SRC_A[WIDTH-1];
                     divz_d  = (SRC_B == '0);
                     rem_d   = '0;
                     div_d   = 1'b1;
                     cnt_d   = N_DIV;
                     state_d = S_DIV;
                  end
                  3'b100:  hi_d = SRC_A;
                  3'b101:  lo_d = SRC_A;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_d = mul_sh[W2-1:0];
            opa_d = opa_q >> MUL_BITS;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_DIV: begin
            rem_d = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], div_ok};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         default: begin
            if (div_q) begin
               lo_d = quo;
               hi_d = rem;
            end else begin
               lo_d = prod[WIDTH-1:0];
               hi_d = prod[W2-1:WIDTH];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase

      if (FLUSH) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         divz_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         divz_q  <= divz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign BUSY  = (state_q != S_IDLE);
   assign STALL = BUSY & (START | MF_REQ);
   assign DONE  = done_q;
   assign HI    = hi_q;
   assign LO    = lo_q;

endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter: radix-2 and radix-16 instances
// share operands; each has its own START.
module tb_md_unit_iter;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_NOP   = 3'b110;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic [2:0]  OP = OP_NOP;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        MF_REQ = 1'b0;
   logic        FLUSH = 1'b0;

   logic        busy0, stall0, done0;
   logic        busy1, stall1, done1;
   logic [31:0] hi0, lo0, hi1, lo1;

   int n_chk = 0;
   int n_fail = 0;
   int lat0, lat1, bz0, bz1;

   md_unit_iter #(.WIDTH(32), .MUL_BITS(1)) dut0 (
      .CLK(CLK), .RESET(RESET), .START(start0), .OP(OP),
      .SRC_A(A), .SRC_B(B), .MF_REQ(MF_REQ), .FLUSH(FLUSH),
      .BUSY(busy0), .STALL(stall0), .DONE(done0),
      .HI(hi0), .LO(lo0)
   );

   md_unit_iter #(.WIDTH(32), .MUL_BITS(4)) dut1 (
      .CLK(CLK), .RESET(RESET), .START(start1), .OP(OP),
      .SRC_A(A), .SRC_B(B), .MF_REQ(MF_REQ), .FLUSH(FLUSH),
      .BUSY(busy1), .STALL(stall1), .DONE(done1),
      .HI(hi1), .LO(lo1)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Issue one op to both instances, then record DONE latency and BUSY cycles.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge CLK);
      start0 = 1'b1; start1 = 1'b1; OP = op; A = a; B = b;
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0; start1 = 1'b0; OP = OP_NOP; A = ~a; B = ~b;
      lat0 = 0; lat1 = 0; bz0 = 0; bz1 = 0;
      for (int k = 0; k < 80; k++) begin
         if (busy0) bz0++;
         if (busy1) bz1++;
         if (done0 && lat0 == 0) lat0 = k;
         if (done1 && lat1 == 0) lat1 = k;
         if (lat0 != 0 && lat1 != 0) break;
         @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      n_chk++;
      if (hi0 !== 32'h0 || lo0 !== 32'h0) begin
         n_fail++; $display("FAIL reset hilo0 got %h/%h exp 0/0", hi0, lo0);
      end
      n_chk++;
      if (hi1 !== 32'h0 || lo1 !== 32'h0) begin
         n_fail++; $display("FAIL reset hilo1 got %h/%h exp 0/0", hi1, lo1);
      end
      n_chk++;
      if ({busy0, done0, stall0, busy1, done1, stall1} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset ctl got %b exp 000000",
                  {busy0, done0, stall0, busy1, done1, stall1});
      end
   endtask

   task automatic test_mult;
      issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
      n_chk++;
      if (lat0 !== 33 || bz0 !== 33) begin
         n_fail++; $display("FAIL mult lat0/busy0 got %0d/%0d exp 33/33", lat0, bz0);
      end
      n_chk++;
      if (lat1 !== 9 || bz1 !== 9) begin
         n_fail++; $display("FAIL mult lat1/busy1 got %0d/%0d exp 9/9", lat1, bz1);
      end
      n_chk++;
      if (hi0 !== 32'hFFFFFFFF || lo0 !== 32'hFFFFFFF1) begin
         n_fail++; $display("FAIL mult r0 got %h_%h exp ffffffff_fffffff1", hi0, lo0);
      end
      n_chk++;
      if (hi1 !== 32'hFFFFFFFF || lo1 !== 32'hFFFFFFF1) begin
         n_fail++; $display("FAIL mult r1 got %h_%h exp ffffffff_fffffff1", hi1, lo1);
      end
   endtask

   task automatic test_multu;
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      n_chk++;
      if (lat1 !== 9) begin
         n_fail++; $display("FAIL multu lat1 got %0d exp 9", lat1);
      end
      n_chk++;
      if (hi1 !== 32'hFFFFFFFE || lo1 !== 32'h00000001) begin
         n_fail++; $display("FAIL multu r1 got %h_%h exp fffffffe_00000001", hi1, lo1);
      end
      n_chk++;
      if (hi0 !== 32'hFFFFFFFE || lo0 !== 32'h00000001) begin
         n_fail++; $display("FAIL multu r0 got %h_%h exp fffffffe_00000001", hi0, lo0);
      end
      issue(OP_MULT, 32'h80000000, 32'h80000000);
      n_chk++;
      if (hi1 !== 32'h40000000 || lo1 !== 32'h0) begin
         n_fail++; $display("FAIL mult_min r1 got %h_%h exp 40000000_00000000", hi1, lo1);
      end
      n_chk++;
      if (hi0 !== 32'h40000000 || lo0 !== 32'h0) begin
         n_fail++; $display("FAIL mult_min r0 got %h_%h exp 40000000_00000000", hi0, lo0);
      end
   endtask

   task automatic test_div;
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
      n_chk++;
      if (lat0 !== 33 || lat1 !== 33 || bz1 !== 33) begin
         n_fail++;
         $display("FAIL div lat got %0d/%0d busy %0d exp 33/33/33", lat0, lat1, bz1);
      end
      n_chk++;
      if (lo0 !== 32'hFFFFFFFD || hi0 !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL div_neg got lo %h hi %h exp fffffffd ffffffff", lo0, hi0);
      end
      issue(OP_DIVU, 32'd100, 32'd7);
      n_chk++;
      if (lo0 !== 32'd14 || hi0 !== 32'd2) begin
         n_fail++; $display("FAIL divu got lo %0d hi %0d exp 14 2", lo0, hi0);
      end
      n_chk++;
      if (lo1 !== 32'd14 || hi1 !== 32'd2) begin
         n_fail++; $display("FAIL divu r1 got lo %0d hi %0d exp 14 2", lo1, hi1);
      end
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      n_chk++;
      if (lo0 !== 32'h80000000 || hi0 !== 32'h0) begin
         n_fail++; $display("FAIL div_min got lo %h hi %h exp 80000000 0", lo0, hi0);
      end
   endtask

   task automatic test_divzero;
      issue(OP_DIVU, 32'h00001234, 32'h0);
      n_chk++;
      if (lat0 !== 33) begin
         n_fail++; $display("FAIL divz lat got %0d exp 33", lat0);
      end
      n_chk++;
      if (hi0 !== 32'h00001234 || lo0 !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL divuz got hi %h lo %h exp 00001234 ffffffff", hi0, lo0);
      end
      issue(OP_DIV, 32'hFFFFFFFB, 32'h0);
      n_chk++;
      if (hi0 !== 32'hFFFFFFFB || lo0 !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL divsz got hi %h lo %h exp fffffffb ffffffff", hi0, lo0);
      end
   endtask

   task automatic test_flush;
      logic seen;
      @(negedge CLK);
      start0 = 1'b1; start1 = 1'b1; OP = OP_DIV; A = 32'd100; B = 32'd7;
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0; start1 = 1'b0; OP = OP_NOP;
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      n_chk++;
      if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
         n_fail++; $display("FAIL flush pre busy got %b%b exp 11", busy0, busy1);
      end
      FLUSH = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      FLUSH = 1'b0;
      n_chk++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL flush busy got %b%b exp 00", busy0, busy1);
      end
      n_chk++;
      if (hi0 !== 32'hFFFFFFFB || lo0 !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL flush hilo got %h/%h exp fffffffb/ffffffff", hi0, lo0);
      end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done0 || done1) seen = 1'b1;
         @(negedge CLK);
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL flush done got 1 exp 0");
      end
      start0 = 1'b1; start1 = 1'b1; OP = OP_MTLO; A = 32'h0000ABCD;
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0; start1 = 1'b0; OP = OP_NOP;
      n_chk++;
      if (lo0 !== 32'h0000ABCD || hi0 !== 32'hFFFFFFFB) begin
         n_fail++; $display("FAIL mtlo got lo %h hi %h exp 0000abcd fffffffb", lo0, hi0);
      end
      n_chk++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         n_fail++; $display("FAIL mtlo ctl got busy %b done %b exp 0 0", busy0, done0);
      end
      start0 = 1'b1; start1 = 1'b1; OP = OP_MTHI; A = 32'h12345678;
      FLUSH = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      FLUSH = 1'b0;
      n_chk++;
      if (hi0 !== 32'hFFFFFFFB) begin
         n_fail++; $display("FAIL flush_mthi got %h exp fffffffb", hi0);
      end
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0; start1 = 1'b0; OP = OP_NOP;
      n_chk++;
      if (hi0 !== 32'h12345678 || hi1 !== 32'h12345678) begin
         n_fail++; $display("FAIL mthi got %h/%h exp 12345678", hi0, hi1);
      end
      start0 = 1'b1; OP = OP_NOP; A = 32'h1;
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0;
      n_chk++;
      if (busy0 !== 1'b0 || hi0 !== 32'h12345678 || lo0 !== 32'h0000ABCD) begin
         n_fail++;
         $display("FAIL nop got busy %b hi %h lo %h exp 0 12345678 0000abcd",
                  busy0, hi0, lo0);
      end
   endtask

   task automatic test_stall;
      int k;
      @(negedge CLK);
      start0 = 1'b1; OP = OP_MULT; A = 32'd3; B = 32'd4;
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0; OP = OP_NOP; MF_REQ = 1'b1;
      #1;
      n_chk++;
      if (stall0 !== 1'b1 || stall1 !== 1'b0) begin
         n_fail++; $display("FAIL mf_stall got %b%b exp 10", stall0, stall1);
      end
      @(negedge CLK);
      MF_REQ = 1'b0;
      start0 = 1'b1; OP = OP_MULT; A = 32'hFFFFFFF9; B = 32'd3;
      k = 0;
      while (busy0 && k < 60) begin
         #1;
         n_chk++;
         if (stall0 !== 1'b1) begin
            n_fail++; $display("FAIL start_stall cyc %0d got 0 exp 1", k);
         end
         @(negedge CLK);
         k++;
      end
      n_chk++;
      if (k !== 32) begin
         n_fail++; $display("FAIL stall_cycles got %0d exp 32", k);
      end
      MF_REQ = 1'b1;
      #1;
      n_chk++;
      if (done0 !== 1'b1 || stall0 !== 1'b0) begin
         n_fail++; $display("FAIL done_cyc got done %b stall %b exp 1 0", done0, stall0);
      end
      n_chk++;
      if (hi0 !== 32'h0 || lo0 !== 32'd12) begin
         n_fail++; $display("FAIL mult1 got %h_%h exp 00000000_0000000c", hi0, lo0);
      end
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0; MF_REQ = 1'b0; OP = OP_NOP;
      n_chk++;
      if (busy0 !== 1'b1) begin
         n_fail++; $display("FAIL accept2 busy got %b exp 1", busy0);
      end
      for (int j = 0; j < 50; j++) begin
         if (done0) break;
         @(negedge CLK);
      end
      n_chk++;
      if (done0 !== 1'b1 || hi0 !== 32'hFFFFFFFF || lo0 !== 32'hFFFFFFEB) begin
         n_fail++;
         $display("FAIL mult2 got done %b %h_%h exp 1 ffffffff_ffffffeb",
                  done0, hi0, lo0);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge CLK);
      start0 = 1'b1; start1 = 1'b1; OP = OP_DIV; A = 32'd100; B = 32'd7;
      @(posedge CLK);
      @(negedge CLK);
      start0 = 1'b0; start1 = 1'b0; OP = OP_NOP;
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      n_chk++;
      if (hi0 !== 32'h0 || lo0 !== 32'h0 || hi1 !== 32'h0 || lo1 !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid hilo got %h %h %h %h exp 0", hi0, lo0, hi1, lo1);
      end
      n_chk++;
      if ({busy0, done0, busy1, done1} !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_mid ctl got %b exp 0000", {busy0, done0, busy1, done1});
      end
      seen_done_after_reset();
   endtask

   task automatic seen_done_after_reset;
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (done0 || done1 || busy0 || busy1) seen = 1'b1;
         @(negedge CLK);
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid resumed got activity exp none");
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_divzero();
      test_flush();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
